// File: rtl/dp_ram_ctrl.sv
// -----------------------------------------------------------------------------
// dp_ram_ctrl
//
// True dual-port synchronous RAM. Ports A and B are fully independent and share
// one clock. It adds:
//   - a sequenced clear engine. After reset it zeroes the array one word per
//     cycle, and init_busy stays high until the last word is written.
//   - a read latency of 1 or 2 cycles, with a one-cycle valid strobe per read.
//   - a write-collision flag for the case where both ports write the same
//     address in the same cycle.
//
// Parameters:
//   DATA_W  data word width
//   ADDR_W  address width; the depth is 2**ADDR_W words
//   RD_LAT  read latency in cycles (1 or 2). Any value other than 2 behaves as 1.
//
// Ports:
//   clk, rst              clock and synchronous active-high reset
//   a_en/a_we/a_addr/a_din   port A request: a write when a_we=1, else a read
//   a_dout/a_valid        port A read data and its one-cycle valid strobe
//   b_*                   port B, identical to port A
//   init_busy             high while the clear engine runs; requests are dropped
//   collision             one-cycle pulse after both ports write one address
//
// Optional feature: when DP_RAM_PARITY_EN is defined, each word stores an
// even-parity bit. That build adds the input perr_inj, which inverts the stored
// parity on a write, and the outputs a_perr and b_perr, which flag a parity
// mismatch together with the matching valid strobe.
// -----------------------------------------------------------------------------
module dp_ram_ctrl #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_en,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_din,
  output logic [DATA_W-1:0] a_dout,
  output logic              a_valid,
  input  logic              b_en,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_din,
  output logic [DATA_W-1:0] b_dout,
  output logic              b_valid,
`ifdef DP_RAM_PARITY_EN
  input  logic              perr_inj,
  output logic              a_perr,
  output logic              b_perr,
`endif
  output logic              init_busy,
  output logic              collision
);

`ifdef DP_RAM_PARITY_EN
  localparam int PAR_W = 1;
`else
  localparam int PAR_W = 0;
`endif
  localparam int WORD_W = DATA_W + PAR_W;
  localparam int DEPTH  = 1 << ADDR_W;

  typedef enum logic {ST_INIT, ST_READY} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              clr_we;

  // Ports are folded into 2-entry arrays (index 0 = A, index 1 = B) so that
  // the read pipeline is written once and generated for each port.
  logic [1:0]        en, we, wr, rd;
  logic [ADDR_W-1:0] addr  [2];
  logic [DATA_W-1:0] din   [2];
  logic [WORD_W-1:0] wword [2];
  logic [WORD_W-1:0] oword [2];
  logic [1:0]        ovalid;
  logic              ready;
  logic              same_addr;

  logic [WORD_W-1:0] mem [DEPTH];

  // Physical write ports. The clear engine borrows port A's write path.
  logic              pa_we, pb_we;
  logic [ADDR_W-1:0] pa_addr;
  logic [WORD_W-1:0] pa_data;

  assign en      = {b_en, a_en};
  assign we      = {b_we, a_we};
  assign addr[0] = a_addr;
  assign addr[1] = b_addr;
  assign din[0]  = a_din;
  assign din[1]  = b_din;

  // ---------------------------------------------------------------------------
  // Clear-engine FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    clr_we    = 1'b0;
    init_busy = 1'b0;
    case (state_q)
      ST_INIT: begin
        init_busy = 1'b1;
        clr_we    = ~rst;
        cnt_d     = cnt_q + 1'b1;
        if (cnt_q == '1) begin
          state_d = ST_READY;
        end
      end
      ST_READY: begin
        state_d = ST_READY;
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  // A request is accepted only when the array is usable and the block is not
  // being reset.
  assign ready     = (state_q == ST_READY) && !rst;
  assign wr        = {2{ready}} & en & we;
  assign rd        = {2{ready}} & en & ~we;
  assign same_addr = (addr[0] == addr[1]);

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  genvar gi;
  for (gi = 0; gi < 2; gi++) begin : g_wword
`ifdef DP_RAM_PARITY_EN
    // Even parity: the XOR of the stored word is 0 when it is intact.
    assign wword[gi] = {(^din[gi]) ^ perr_inj, din[gi]};
`else
    assign wword[gi] = din[gi];
`endif
  end

  assign pa_we   = clr_we | wr[0];
  assign pa_addr = clr_we ? cnt_q : addr[0];
  assign pa_data = clr_we ? '0 : wword[0];
  // When both ports write the same address, port A's data is kept.
  assign pb_we   = wr[1] & ~(wr[0] & same_addr);

  always_ff @(posedge clk) begin
    if (pa_we) begin
      mem[pa_addr] <= pa_data;
    end
    if (pb_we) begin
      mem[addr[1]] <= wword[1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      collision <= 1'b0;
    end else begin
      collision <= wr[0] & wr[1] & same_addr;
    end
  end

  // ---------------------------------------------------------------------------
  // Per-port read pipeline. The first stage is the RAM's registered read, which
  // returns the pre-write contents when the other port writes the same address.
  // Output registers load only on a read, so dout holds between reads.
  // ---------------------------------------------------------------------------
  for (gi = 0; gi < 2; gi++) begin : g_port
    logic [WORD_W-1:0] word1_q;
    logic              valid1_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        word1_q  <= '0;
        valid1_q <= 1'b0;
      end else begin
        valid1_q <= rd[gi];
        if (rd[gi]) begin
          word1_q <= mem[addr[gi]];
        end
      end
    end

    if (RD_LAT == 2) begin : g_lat2
      logic [WORD_W-1:0] word2_q;
      logic              valid2_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          word2_q  <= '0;
          valid2_q <= 1'b0;
        end else begin
          valid2_q <= valid1_q;
          if (valid1_q) begin
            word2_q <= word1_q;
          end
        end
      end

      assign oword[gi]  = word2_q;
      assign ovalid[gi] = valid2_q;
    end else begin : g_lat1
      assign oword[gi]  = word1_q;
      assign ovalid[gi] = valid1_q;
    end
  end

  assign a_dout  = oword[0][DATA_W-1:0];
  assign b_dout  = oword[1][DATA_W-1:0];
  assign a_valid = ovalid[0];
  assign b_valid = ovalid[1];

`ifdef DP_RAM_PARITY_EN
  // The XOR of data and stored parity is 1 exactly when they disagree.
  assign a_perr = ovalid[0] & (^oword[0]);
  assign b_perr = ovalid[1] & (^oword[1]);
`endif

endmodule

// File: tb/tb_dp_ram_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dp_ram_ctrl
//
// Directed testbench for dp_ram_ctrl. It uses two instances on one clock:
//   u_dut1  ADDR_W=8, RD_LAT=1  dual access, collision, read-during-write, parity
//   u_dut2  ADDR_W=4, RD_LAT=2  clear sequence, streaming, reset mid-stream
// Inputs change 1 ns after each rising edge, and outputs are sampled there.
// -----------------------------------------------------------------------------
module tb_dp_ram_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance 1 signals
  logic       rst1;
  logic       a_en1, a_we1, b_en1, b_we1;
  logic [7:0] a_addr1, b_addr1, a_din1, b_din1, a_dout1, b_dout1;
  logic       a_valid1, b_valid1, init_busy1, collision1;

  // Instance 2 signals
  logic       rst2;
  logic       a_en2, a_we2, b_en2, b_we2;
  logic [3:0] a_addr2, b_addr2;
  logic [7:0] a_din2, b_din2, a_dout2, b_dout2;
  logic       a_valid2, b_valid2, init_busy2, collision2;

`ifdef DP_RAM_PARITY_EN
  logic perr_inj1, a_perr1, b_perr1;
  logic perr_inj2, a_perr2, b_perr2;
`endif

  dp_ram_ctrl #(.DATA_W(8), .ADDR_W(8), .RD_LAT(1)) u_dut1 (
    .clk(clk), .rst(rst1),
    .a_en(a_en1), .a_we(a_we1), .a_addr(a_addr1), .a_din(a_din1),
    .a_dout(a_dout1), .a_valid(a_valid1),
    .b_en(b_en1), .b_we(b_we1), .b_addr(b_addr1), .b_din(b_din1),
    .b_dout(b_dout1), .b_valid(b_valid1),
`ifdef DP_RAM_PARITY_EN
    .perr_inj(perr_inj1), .a_perr(a_perr1), .b_perr(b_perr1),
`endif
    .init_busy(init_busy1), .collision(collision1)
  );

  dp_ram_ctrl #(.DATA_W(8), .ADDR_W(4), .RD_LAT(2)) u_dut2 (
    .clk(clk), .rst(rst2),
    .a_en(a_en2), .a_we(a_we2), .a_addr(a_addr2), .a_din(a_din2),
    .a_dout(a_dout2), .a_valid(a_valid2),
    .b_en(b_en2), .b_we(b_we2), .b_addr(b_addr2), .b_din(b_din2),
    .b_dout(b_dout2), .b_valid(b_valid2),
`ifdef DP_RAM_PARITY_EN
    .perr_inj(perr_inj2), .a_perr(a_perr2), .b_perr(b_perr2),
`endif
    .init_busy(init_busy2), .collision(collision2)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
    $display("check %-24s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle1();
    a_en1 = 1'b0; a_we1 = 1'b0; a_addr1 = '0; a_din1 = '0;
    b_en1 = 1'b0; b_we1 = 1'b0; b_addr1 = '0; b_din1 = '0;
`ifdef DP_RAM_PARITY_EN
    perr_inj1 = 1'b0;
`endif
  endtask

  task automatic idle2();
    a_en2 = 1'b0; a_we2 = 1'b0; a_addr2 = '0; a_din2 = '0;
    b_en2 = 1'b0; b_we2 = 1'b0; b_addr2 = '0; b_din2 = '0;
`ifdef DP_RAM_PARITY_EN
    perr_inj2 = 1'b0;
`endif
  endtask

  int busy1, busy2, v2seen, vseen;

  initial begin
    rst1 = 1'b1;
    rst2 = 1'b1;
    idle1();
    idle2();
    step();
    step();

    // Reset state
    chk("rst_a_dout1", a_dout1, 8'h00);
    chk("rst_a_valid1", a_valid1, 1'b0);
    chk("rst_collision1", collision1, 1'b0);
    chk("rst_init_busy1", init_busy1, 1'b1);
    chk("rst_b_valid2", b_valid2, 1'b0);
    chk("rst_init_busy2", init_busy2, 1'b1);

    // Clear sequence. Instance 2 holds a write of 0xFF to address 3 for the
    // whole clear; that write must be dropped.
    a_en2 = 1'b1; a_we2 = 1'b1; a_addr2 = 4'd3; a_din2 = 8'hFF;
    rst1 = 1'b0;
    rst2 = 1'b0;
    busy1 = 0; busy2 = 0; v2seen = 0;
    for (int i = 0; i < 400; i++) begin
      if (init_busy1) busy1++;
      if (init_busy2) busy2++; else idle2();
      if (a_valid2) v2seen++;
      if (!init_busy1 && !init_busy2) break;
      step();
    end
    chk("init_edges2", busy2, 16);
    chk("init_edges1", busy1, 256);
    chk("init_no_valid2", v2seen, 0);

    // A read of address 3 returns the cleared value after 2 cycles.
    a_en2 = 1'b1; a_we2 = 1'b0; a_addr2 = 4'd3;
    step();
    idle2();
    chk("clr_rd_lat2_early", a_valid2, 1'b0);
    step();
    chk("clr_rd_valid", a_valid2, 1'b1);
    chk("clr_rd_data", a_dout2, 8'h00);
    step();
    chk("clr_rd_pulse", a_valid2, 1'b0);

    // Basic dual access on instance 1
    a_en1 = 1'b1; a_we1 = 1'b1; a_addr1 = 8'h10; a_din1 = 8'h5A;
    b_en1 = 1'b1; b_we1 = 1'b1; b_addr1 = 8'h20; b_din1 = 8'hC3;
    step();
    chk("dual_wr_no_valid", a_valid1, 1'b0);
    a_we1 = 1'b0; a_addr1 = 8'h20;
    b_we1 = 1'b0; b_addr1 = 8'h10;
    step();
    idle1();
    chk("dual_a_valid", a_valid1, 1'b1);
    chk("dual_a_dout", a_dout1, 8'hC3);
    chk("dual_b_valid", b_valid1, 1'b1);
    chk("dual_b_dout", b_dout1, 8'h5A);
    step();
    chk("dual_a_valid_drop", a_valid1, 1'b0);
    chk("dual_a_dout_hold", a_dout1, 8'hC3);

    // Write collision: port A's data is kept.
    a_en1 = 1'b1; a_we1 = 1'b1; a_addr1 = 8'h05; a_din1 = 8'h11;
    b_en1 = 1'b1; b_we1 = 1'b1; b_addr1 = 8'h05; b_din1 = 8'h22;
    step();
    idle1();
    chk("coll_pulse", collision1, 1'b1);
    step();
    chk("coll_one_cycle", collision1, 1'b0);
    a_en1 = 1'b1; a_addr1 = 8'h05;
    b_en1 = 1'b1; b_addr1 = 8'h05;
    step();
    idle1();
    chk("coll_a_data", a_dout1, 8'h11);
    chk("coll_b_same_read", b_dout1, 8'h11);
    chk("both_read_no_coll", collision1, 1'b0);

    // Read during write on the other port returns the old data.
    a_en1 = 1'b1; a_we1 = 1'b1; a_addr1 = 8'h07; a_din1 = 8'hAA;
    step();
    a_din1 = 8'hBB;
    b_en1 = 1'b1; b_we1 = 1'b0; b_addr1 = 8'h07;
    step();
    idle1();
    chk("rdw_b_old", b_dout1, 8'hAA);
    chk("rdw_b_valid", b_valid1, 1'b1);
    chk("rdw_no_coll", collision1, 1'b0);
    b_en1 = 1'b1; b_addr1 = 8'h07;
    step();
    idle1();
    chk("rdw_b_new", b_dout1, 8'hBB);

    // Same-port read after write on consecutive cycles
    a_en1 = 1'b1; a_we1 = 1'b1; a_addr1 = 8'h08; a_din1 = 8'h33;
    step();
    a_we1 = 1'b0;
    step();
    idle1();
    chk("raw_same_port", a_dout1, 8'h33);

    // Streaming on instance 2 (RD_LAT=2)
    for (int i = 0; i < 3; i++) begin
      a_en2 = 1'b1; a_we2 = 1'b1; a_addr2 = 4'(i); a_din2 = 8'(i + 1);
      step();
    end
    a_we2 = 1'b0; a_addr2 = 4'd0;
    step();
    chk("strm_e1_valid", a_valid2, 1'b0);
    a_addr2 = 4'd1;
    step();
    chk("strm_e2_valid", a_valid2, 1'b1);
    chk("strm_e2_data", a_dout2, 8'h01);
    a_addr2 = 4'd2;
    step();
    idle2();
    chk("strm_e3_valid", a_valid2, 1'b1);
    chk("strm_e3_data", a_dout2, 8'h02);
    step();
    chk("strm_e4_valid", a_valid2, 1'b1);
    chk("strm_e4_data", a_dout2, 8'h03);
    step();
    chk("strm_e5_valid", a_valid2, 1'b0);

    // Reset mid-stream: a read in flight is flushed, then the array is re-cleared.
    a_en2 = 1'b1; a_we2 = 1'b0; a_addr2 = 4'd0;
    step();
    a_addr2 = 4'd1;
    rst2 = 1'b1;
    step();
    rst2 = 1'b0;
    idle2();
    chk("mid_rst_valid", a_valid2, 1'b0);
    chk("mid_rst_dout", a_dout2, 8'h00);
    chk("mid_rst_busy", init_busy2, 1'b1);
    vseen = 0;
    for (int i = 0; i < 40; i++) begin
      if (a_valid2) vseen++;
      if (!init_busy2) break;
      step();
    end
    chk("mid_rst_no_valid", vseen, 0);
    chk("mid_rst_ready", init_busy2, 1'b0);
    a_en2 = 1'b1; a_addr2 = 4'd1;
    step();
    idle2();
    step();
    chk("reclr_valid", a_valid2, 1'b1);
    chk("reclr_data", a_dout2, 8'h00);

`ifdef DP_RAM_PARITY_EN
    // Parity on instance 1
    a_en1 = 1'b1; a_we1 = 1'b1; a_addr1 = 8'h09; a_din1 = 8'h0F; perr_inj1 = 1'b1;
    step();
    a_we1 = 1'b0; perr_inj1 = 1'b0;
    step();
    idle1();
    chk("par_inj_valid", a_valid1, 1'b1);
    chk("par_inj_perr", a_perr1, 1'b1);
    a_en1 = 1'b1; a_we1 = 1'b1; a_addr1 = 8'h09; a_din1 = 8'h0F;
    step();
    a_we1 = 1'b0;
    step();
    idle1();
    chk("par_ok_valid", a_valid1, 1'b1);
    chk("par_ok_perr", a_perr1, 1'b0);
    step();
    chk("par_perr_pulse", a_perr1, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dp_ram_ctrl.md
Name: dp_ram_ctrl

Overview:
Parametrised true dual-port synchronous RAM with two fully independent read/write ports (A, B) on a single clock. A sequenced clear engine replaces the single-cycle array reset, so `init_busy` reports when the memory is usable. Adds configurable read latency, per-read valid strobes and cross-port write-collision detection. Drop-in storage for datapath blocks needing concurrent producer/consumer access.

Parameters:
- DATA_W, 8, data word width in bits.
- ADDR_W, 8, address width in bits; depth = 2**ADDR_W words.
- RD_LAT, 1, read latency in cycles; legal values are 1 and 2 only.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- a_en  in  1  port A request.
- a_we  in  1  port A write (1) / read (0); qualified by a_en.
- a_addr  in  ADDR_W  port A address.
- a_din  in  DATA_W  port A write data.
- a_dout  out  DATA_W  port A read data.
- a_valid  out  1  one-cycle pulse: a_dout holds a new read result.
- b_en, b_we, b_addr, b_din, b_dout, b_valid: same as port A, for port B.
- init_busy  out  1  high while the clear engine runs; requests are ignored.
- collision  out  1  one-cycle pulse: both ports wrote the same address.

Behaviour:
- Reset is synchronous, active-high, clock clk.
- While rst is high, on each edge:
  - FSM goes to INIT and the clear counter is set to 0.
  - a_dout, b_dout, a_valid, b_valid and collision are all set to 0.
  - All RD_LAT pipeline stages are flushed.
  - init_busy is 1.
- FSM states: INIT and READY.
- INIT state:
  - Each edge with rst low writes mem[cnt] <= 0 and increments cnt.
  - After the edge that writes address 2**ADDR_W-1, the FSM goes to READY and init_busy drops.
  - init_busy is therefore high for exactly 2**ADDR_W edges after rst falls.
  - Port requests in INIT are dropped: no write, no valid pulse.
- Reset mid-INIT restarts the clear from address 0. Reset in READY re-clears the whole array.
- READY state, per port, independently:
  - en & we: write mem[addr] <= din at the edge.
  - en & !we: read mem[addr].
  - RD_LAT=1: dout and valid update at the request edge + 1.
  - RD_LAT=2: dout and valid update one cycle later; the pipeline accepts a new read every cycle.
  - dout holds its last read value when valid is 0.
- Cross-port boundary cases:
  - Both write the same address in the same cycle: port A's data is stored and port B's is discarded. collision pulses on the next cycle, aligned with RD_LAT=1 timing.
  - Write on one port, read of the same address on the other port, same cycle: the read returns the old (pre-write) data. No collision is flagged.
  - Both read the same address: both return identical data. No collision.
  - Same-port read-after-write on consecutive cycles returns the new data.
- Addresses always map within depth; there is no out-of-range case.
- X or unused inputs are ignored when en is 0.

Optional Feature:
- Macro: DP_RAM_PARITY_EN.
- When defined:
  - Each word stores one extra even-parity bit computed from din at write time.
  - New outputs a_perr and b_perr (1 bit each) pulse together with the corresponding valid when the stored parity mismatches the read data.
  - New input perr_inj (1 bit): when high during a write, the stored parity bit is inverted.
  - The clear engine writes parity 0, which is consistent with all-zero data.
  - a_perr and b_perr reset to 0.
- When undefined: no parity storage, and the ports a_perr, b_perr and perr_inj do not exist.

Test Plan:
1. Clear sequence (ADDR_W=4): pulse rst for 1 cycle, hold a_en=1 with a write of 0xFF to address 3 throughout INIT.
   - init_busy must stay high for exactly 16 edges after rst falls.
   - A subsequent read of address 3 must return 0x00 with a_valid pulsed.
2. Basic dual access, RD_LAT=1:
   - A writes 0x5A to address 0x10, B writes 0xC3 to address 0x20 in the same cycle.
   - Next cycle A reads 0x20 and B reads 0x10.
   - Required: a_dout=0xC3 and b_dout=0x5A, both valids high one cycle after the reads.
3. Write collision:
   - A writes 0x11 and B writes 0x22 to address 0x05 in the same cycle.
   - Required: collision=1 on the next cycle only, and a later read of 0x05 returns 0x11.
4. Read-during-write:
   - Address 0x07 holds 0xAA. A writes 0xBB to 0x07 while B reads 0x07 in the same cycle.
   - Required: b_dout=0xAA, collision=0, and the next B read returns 0xBB.
5. RD_LAT=2 streaming:
   - A issues back-to-back reads of addresses 0, 1 and 2, preloaded with 0x01, 0x02, 0x03.
   - Required: a_valid high on edges +2, +3, +4 with data 0x01, 0x02, 0x03.
   - Asserting rst mid-stream clears valid, and no further valid pulses occur.
6. Parity (DP_RAM_PARITY_EN defined):
   - Write 0x0F to address 9 with perr_inj=1, then read address 9.
   - Required: a_perr=1 coincident with a_valid.
   - Rewrite the address with perr_inj=0 and read again: a_perr must be 0.
